// File: rtl/hls_ch_scheduler.sv
// hls_ch_scheduler
// Sequences one HLS-IP job across its stream channels. On start it latches the
// per-channel lengths and ready flags, then issues one streamer request per
// active channel (lowest index first). It counts beats per channel and pulses
// the per-channel and job-done events back to the IP FSM.
//
// Ports
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   clear_i         synchronous soft clear, abandons the running job
//   start_i         one-cycle job start pulse (honoured in IDLE only)
//   ch_len_i        beats per channel, channel i at [i*CNT_W +: CNT_W]
//   ch_rdy_i        per-channel enable for this job
//   req_valid_o     streamer request valid
//   req_ch_o        requested channel index
//   req_len_o       requested beat count
//   req_ready_i     streamer accepts request
//   beat_i          one beat transferred on channel i this cycle
//   ch_done_o       one-cycle pulse when a channel's last beat has counted
//   busy_o          job in progress (ISSUE, RUN, DONE)
//   done_o          one-cycle job-complete pulse
//   err_o           sticky: beat seen on a channel with nothing remaining
module hls_ch_scheduler #(
  parameter  int N_CH  = 2,
  parameter  int CNT_W = 16,
  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic                  start_i,
  input  logic [N_CH*CNT_W-1:0] ch_len_i,
  input  logic [N_CH-1:0]       ch_rdy_i,
  output logic                  req_valid_o,
  output logic [CH_W-1:0]       req_ch_o,
  output logic [CNT_W-1:0]      req_len_o,
  input  logic                  req_ready_i,
  input  logic [N_CH-1:0]       beat_i,
  output logic [N_CH-1:0]       ch_done_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                     state_q;
  logic [N_CH-1:0][CNT_W-1:0] len_in;
  logic [N_CH-1:0][CNT_W-1:0] len_q;
  logic [N_CH-1:0][CNT_W-1:0] rem_q;
  logic [N_CH-1:0][CNT_W-1:0] rem_nxt;
  logic [N_CH-1:0]            act_in;
  logic [N_CH-1:0]            active_q;
  logic [N_CH-1:0]            issued_q;
  logic [N_CH-1:0]            req_oh;
  logic [N_CH-1:0]            pend_after;
  logic [N_CH-1:0]            ch_done_nxt;
  logic [CH_W-1:0]            first_in;
  logic [CH_W-1:0]            first_pend;
  logic                       cnt_en;
  logic                       err_hit;
  logic                       rem_zero;
  logic                       accept;

  // Lowest-index set bit of a channel mask; 0 when the mask is empty.
  function automatic logic [CH_W-1:0] first_set(input logic [N_CH-1:0] m);
    logic [CH_W-1:0] idx;
    idx = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (m[i]) idx = CH_W'(i);
    end
    return idx;
  endfunction

  always_comb begin
    len_in = '0;
    act_in = '0;
    for (int i = 0; i < N_CH; i++) begin
      len_in[i] = ch_len_i[i*CNT_W +: CNT_W];
      act_in[i] = ch_rdy_i[i] && (ch_len_i[i*CNT_W +: CNT_W] != '0);
    end
  end

  // Beat counting: counters stop at zero; a beat on an exhausted channel
  // is dropped and flagged instead of wrapping.
  always_comb begin
    rem_nxt     = rem_q;
    ch_done_nxt = '0;
    err_hit     = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (beat_i[i]) begin
        if (rem_q[i] != '0) begin
          rem_nxt[i]     = rem_q[i] - CNT_W'(1);
          ch_done_nxt[i] = (rem_q[i] == CNT_W'(1));
        end else begin
          err_hit = 1'b1;
        end
      end
    end
  end

  assign cnt_en     = (state_q == S_ISSUE) || (state_q == S_RUN);
  assign rem_zero   = (rem_q == '0);
  assign accept     = req_valid_o && req_ready_i;
  assign req_oh     = N_CH'(1) << req_ch_o;
  assign pend_after = active_q & ~issued_q & ~req_oh;
  assign first_in   = first_set(act_in);
  assign first_pend = first_set(pend_after);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      rem_q       <= '0;
      active_q    <= '0;
      issued_q    <= '0;
      req_valid_o <= 1'b0;
      req_ch_o    <= '0;
      req_len_o   <= '0;
      ch_done_o   <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
    end else if (clear_i) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      rem_q       <= '0;
      active_q    <= '0;
      issued_q    <= '0;
      req_valid_o <= 1'b0;
      req_ch_o    <= '0;
      req_len_o   <= '0;
      ch_done_o   <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      ch_done_o <= '0;
      done_o    <= 1'b0;

      if (cnt_en) begin
        rem_q     <= rem_nxt;
        ch_done_o <= ch_done_nxt;
        if (err_hit) err_o <= 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            len_q    <= len_in;
            active_q <= act_in;
            issued_q <= '0;
            err_o    <= 1'b0;
            busy_o   <= 1'b1;
            for (int i = 0; i < N_CH; i++) begin
              rem_q[i] <= act_in[i] ? len_in[i] : '0;
            end
            if (|act_in) begin
              state_q     <= S_ISSUE;
              req_valid_o <= 1'b1;
              req_ch_o    <= first_in;
              req_len_o   <= len_in[first_in];
            end else begin
              state_q <= S_DONE;
              done_o  <= 1'b1;
            end
          end
        end

        // While a request is outstanding its fields are held; once every
        // channel is issued, valid is low for one cycle and completion is
        // judged from the settled counters.
        S_ISSUE: begin
          if (req_valid_o) begin
            if (accept) begin
              issued_q <= issued_q | req_oh;
              if (|pend_after) begin
                req_ch_o  <= first_pend;
                req_len_o <= len_q[first_pend];
              end else begin
                req_valid_o <= 1'b0;
                req_ch_o    <= '0;
                req_len_o   <= '0;
              end
            end
          end else if (rem_zero) begin
            state_q <= S_DONE;
            done_o  <= 1'b1;
          end else begin
            state_q <= S_RUN;
          end
        end

        S_RUN: begin
          if (rem_zero) begin
            state_q <= S_DONE;
            done_o  <= 1'b1;
          end
        end

        S_DONE: begin
          state_q  <= S_IDLE;
          busy_o   <= 1'b0;
          active_q <= '0;
          issued_q <= '0;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
